// File: rtl/logic_unit_pipe.sv
// Two-stage valid/ready bitwise logic unit (AND/OR/XOR/NAND) with enable gating,
// zero and parity flags on the registered result.
module logic_unit_pipe #(
   parameter int unsigned WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             E,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] Ain,
   input  logic [WIDTH-1:0] Bin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] Y,
   output logic             zero,
   output logic             parity
);

   logic             s1_valid_q, s1_valid_d;
   logic [WIDTH-1:0] s1_a_q, s1_a_d;
   logic [WIDTH-1:0] s1_b_q, s1_b_d;
   logic [1:0]       s1_op_q, s1_op_d;
   logic             s2_valid_q, s2_valid_d;
   logic [WIDTH-1:0] y_q, y_d;
   logic             zero_q, zero_d;
   logic             parity_q, parity_d;
   logic             s2_adv;
   logic             in_xfer;
   logic [WIDTH-1:0] res;

   always_comb begin
      // S2 is free to load when empty or being drained this cycle.
      s2_adv   = s1_valid_q & (~s2_valid_q | out_ready);
      in_ready = ~s1_valid_q | s2_adv;
      in_xfer  = in_valid & in_ready;

      res = '0;
      case (s1_op_q)
         2'b00:   res = s1_a_q & s1_b_q;
         2'b01:   res = s1_a_q | s1_b_q;
         2'b10:   res = s1_a_q ^ s1_b_q;
         default: res = ~(s1_a_q & s1_b_q);
      endcase

      s1_valid_d = s1_valid_q;
      s1_a_d     = s1_a_q;
      s1_b_d     = s1_b_q;
      s1_op_d    = s1_op_q;
      if (in_xfer) begin
         s1_valid_d = 1'b1;
         s1_a_d     = Ain & {WIDTH{E}};
         s1_b_d     = Bin & {WIDTH{E}};
         s1_op_d    = op;
      end else if (s2_adv) begin
         s1_valid_d = 1'b0;
      end

      s2_valid_d = s2_valid_q;
      y_d        = y_q;
      zero_d     = zero_q;
      parity_d   = parity_q;
      if (s2_adv) begin
         s2_valid_d = 1'b1;
         y_d        = res;
         zero_d     = ~|res;
         parity_d   = ^res;
      end else if (out_ready) begin
         s2_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s1_valid_q <= 1'b0;
         s1_a_q     <= '0;
         s1_b_q     <= '0;
         s1_op_q    <= 2'b00;
         s2_valid_q <= 1'b0;
         y_q        <= '0;
         zero_q     <= 1'b0;
         parity_q   <= 1'b0;
      end else begin
         s1_valid_q <= s1_valid_d;
         s1_a_q     <= s1_a_d;
         s1_b_q     <= s1_b_d;
         s1_op_q    <= s1_op_d;
         s2_valid_q <= s2_valid_d;
         y_q        <= y_d;
         zero_q     <= zero_d;
         parity_q   <= parity_d;
      end
   end

   assign out_valid = s2_valid_q;
   assign Y         = y_q;
   assign zero      = zero_q;
   assign parity    = parity_q;

endmodule
